// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches.
//   tx_state_t : transmitter FSM state, 2-bit encoding
//   PAT_110    : default pattern sent on the link
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  localparam logic [2:0] PAT_110 = 3'b110;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. On an accepted start it captures a PAT_W-bit pattern and a
// repeat count, then shifts the pattern out MSB-first (rep_cnt+1) times, optionally separated
// by GAP_CYC idle cycles, and finishes with a one-cycle done pulse. Registered Moore outputs.
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   start      : transmit request, sampled only in IDLE
//   pattern    : pattern to send, captured on accepted start
//   rep_cnt    : extra repetitions (total sends = rep_cnt+1), captured on accepted start
//   abort      : synchronous abort of a frame in progress
//   dout       : serial data
//   dout_valid : dout carries a pattern bit
//   busy       : high in any state other than IDLE
//   done       : one-cycle pulse after the last bit of the last repetition
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned PAT_W   = 3,
  parameter int unsigned GAP_CYC = 1,
  parameter int unsigned REP_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned GapW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  localparam logic [BitW-1:0]  BitLast = BitW'(PAT_W - 1);
  localparam logic [BitW-1:0]  BitOne  = BitW'(1);
  localparam logic [GapW-1:0]  GapLoad = GapW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [GapW-1:0]  GapOne  = GapW'(1);
  localparam logic [REP_W-1:0] RepOne  = REP_W'(1);

  tx_state_t        state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    reps_d    = reps_q;
    gap_cnt_d = gap_cnt_q;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = SHIFT;
            shreg_d   = pattern;
            pat_d     = pattern;
            bit_cnt_d = BitLast;
            reps_d    = rep_cnt;
          end
        end
        SHIFT: begin
          if (bit_cnt_q == '0) begin
            if (reps_q != '0) begin
              if (GAP_CYC > 0) begin
                state_d   = GAP;
                gap_cnt_d = GapLoad;
              end else begin
                // Back-to-back: reload from the captured copy without leaving SHIFT.
                shreg_d   = pat_q;
                reps_d    = reps_q - RepOne;
                bit_cnt_d = BitLast;
              end
            end else begin
              state_d = DONE;
            end
          end else begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q - BitOne;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_d   = SHIFT;
            shreg_d   = pat_q;
            reps_d    = reps_q - RepOne;
            bit_cnt_d = BitLast;
          end else begin
            gap_cnt_d = gap_cnt_q - GapOne;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and outputs; outputs are decoded from next-state registers so they stay Moore.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dout       <= (state_d == SHIFT) & shreg_d[PAT_W-1];
      dout_valid <= (state_d == SHIFT);
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE);
    end
  end

  // Datapath: shift register, captured pattern copy and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q   <= '0;
      pat_q     <= '0;
      bit_cnt_q <= '0;
      reps_q    <= '0;
      gap_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      bit_cnt_q <= bit_cnt_d;
      reps_q    <= reps_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule
